// File: rtl/fwd_pkg.sv
// Shared types and constants for the EX-stage forwarding / hazard controller.
//   FWD_*      : select encodings, ordered to match the 3:1 operand mux inputs
//   pipe_rec_t : shadow record of an instruction held in EX or MEM
//   is_writer  : record will write a non-zero architectural register
package fwd_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [1:0] FWD_EX = 2'b10;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic             memread;
    logic [REG_W-1:0] dest;
  } pipe_rec_t;

  // Register 0 is hardwired, so it never produces a hazard.
  function automatic logic is_writer(input pipe_rec_t rec);
    return rec.valid & rec.regwrite & (rec.dest != REG_ZERO);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand producer match against the EX and MEM shadow records.
//   src, uses  : source specifier and its read-enable
//   ex_rec     : instruction currently in EX
//   mem_rec    : instruction currently in MEM
//   sel_c      : combinational forwarding select (newest producer wins)
//   load_hit_c : src is produced by a load still in EX (needs a stall)
module fwd_match
  import fwd_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             uses,
  input  pipe_rec_t        ex_rec,
  input  pipe_rec_t        mem_rec,
  output logic [1:0]       sel_c,
  output logic             load_hit_c
);

  logic ex_hit;
  logic mem_hit;

  // A load in EX has no data yet, so it falls through to the MEM check;
  // the resulting bubble discards that select anyway.
  always_comb begin
    ex_hit     = uses & is_writer(ex_rec) & (src == ex_rec.dest);
    mem_hit    = uses & is_writer(mem_rec) & (src == mem_rec.dest);
    load_hit_c = ex_hit & ex_rec.memread;
    sel_c      = FWD_RF;
    if (ex_hit && !ex_rec.memread) begin
      sel_c = FWD_EX;
    end else if (mem_hit) begin
      sel_c = FWD_WB;
    end
  end

endmodule

// File: rtl/forward_hazard_ctrl.sv
// Operand forwarding selects and load-use stall control for a 5-stage pipe.
//   Clk, Rst         : clock, synchronous active-high reset
//   id_*             : decode fields of the instruction in ID
//   ex_flush         : taken branch/jump, discard the ID instruction
//   fwd_a_sel/b_sel  : registered EX operand mux selects
//   stall            : combinational, hold PC and IF/ID
//   idex_bubble      : combinational, load a NOP into ID/EX
//   stall_cnt        : number of stalled cycles since reset (wraps)
module forward_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  ex_flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall,
  output logic                  idex_bubble,
  output logic [CNT_W-1:0]      stall_cnt
);

  pipe_rec_t        ex_rec,    ex_rec_nxt;
  pipe_rec_t        mem_rec,   mem_rec_nxt;
  logic [1:0]       sel_a_c,   sel_b_c;
  logic [1:0]       fwd_a_nxt, fwd_b_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             load_a_c,  load_b_c;

  fwd_match u_match_a (
    .src        (REG_W'(id_rs)),
    .uses       (id_uses_rs),
    .ex_rec     (ex_rec),
    .mem_rec    (mem_rec),
    .sel_c      (sel_a_c),
    .load_hit_c (load_a_c)
  );

  fwd_match u_match_b (
    .src        (REG_W'(id_rt)),
    .uses       (id_uses_rt),
    .ex_rec     (ex_rec),
    .mem_rec    (mem_rec),
    .sel_c      (sel_b_c),
    .load_hit_c (load_b_c)
  );

  // Hazard decision and next-state: flush overrides a load-use stall.
  always_comb begin
    stall       = (load_a_c | load_b_c) & ~ex_flush;
    idex_bubble = stall | ex_flush;

    mem_rec_nxt = ex_rec;
    ex_rec_nxt  = '{valid:    1'b1,
                    regwrite: id_regwrite,
                    memread:  id_memread,
                    dest:     REG_W'(id_dest)};
    fwd_a_nxt   = sel_a_c;
    fwd_b_nxt   = sel_b_c;
    cnt_nxt     = stall_cnt;

    if (idex_bubble) begin
      ex_rec_nxt = '0;
      fwd_a_nxt  = FWD_RF;
      fwd_b_nxt  = FWD_RF;
    end
    if (stall) begin
      cnt_nxt = stall_cnt + CNT_W'(1);
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ex_rec    <= '0;
      mem_rec   <= '0;
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
      stall_cnt <= '0;
    end else begin
      ex_rec    <= ex_rec_nxt;
      mem_rec   <= mem_rec_nxt;
      fwd_a_sel <= fwd_a_nxt;
      fwd_b_sel <= fwd_b_nxt;
      stall_cnt <= cnt_nxt;
    end
  end

endmodule

// File: doc/forward_hazard_ctrl.md
Name: forward_hazard_ctrl

Overview:
Generates the two registered operand-forwarding selects that drive the EX-stage 32-bit 3:1 operand muxes (A and B). Also produces the load-use stall and bubble control for IF/ID and ID/EX. Keeps its own shadow pipeline of EX and MEM destination records, so it needs only ID-stage decode fields. It sits between ID decode and the ID/EX pipeline register and counts stall cycles for performance reporting.

Parameters:
REG_ADDR_W, 5, register-specifier width
CNT_W, 32, stall counter width

Ports:
Clk  in  1  pipeline clock; all state updates on rising edge
Rst  in  1  synchronous, active-high reset
id_rs  in  REG_ADDR_W  rs specifier of instruction in ID
id_rt  in  REG_ADDR_W  rt specifier of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_dest  in  REG_ADDR_W  decoded destination (rd/rt/31) of ID instruction
id_regwrite  in  1  ID instruction writes register file
id_memread  in  1  ID instruction is a load
ex_flush  in  1  taken branch/jump resolved; discard ID instruction
fwd_a_sel  out  2  EX operand A select: 00 regfile, 01 MEM/WB value, 10 EX/MEM ALU result
fwd_b_sel  out  2  EX operand B select, same encoding
stall  out  1  hold PC and IF/ID this cycle
idex_bubble  out  1  load a NOP into ID/EX this cycle
stall_cnt  out  CNT_W  cycles with stall=1 since reset

Behaviour:
- State: ex_rec and mem_rec, each {valid, regwrite, memread, dest}, plus registered fwd_a_sel/fwd_b_sel and stall_cnt.
- Reset (Rst=1 at edge): both records invalid, dest=0. fwd_*_sel=00, stall_cnt=0. Hence stall=0 and idex_bubble=0 in the cycle after reset. Reset mid-stall clears everything; no pending stall survives.
- "Writer" means a record with valid=1, regwrite=1 and dest!=0. Register 0 is never a hazard and never forwarded.
- load_use (combinational) = ex_rec writer & ex_rec.memread & ((id_uses_rs & id_rs==ex_rec.dest) | (id_uses_rt & id_rt==ex_rec.dest)).
- stall = load_use & ~ex_flush. idex_bubble = stall | ex_flush. Both are combinational from state and inputs, zero latency.
- Each edge (no reset):
  - mem_rec <= ex_rec.
  - ex_rec <= invalid if idex_bubble, else {1, id_regwrite, id_memread, id_dest}.
- Select compute, per operand, with src = id_rs or id_rt gated by the matching uses bit:
  - 10 if src matches ex_rec writer that is not a load;
  - else 01 if src matches mem_rec writer (includes loads);
  - else 00.
  - EX match has priority over MEM (most recent producer wins).
- fwd_*_sel <= 00 when idex_bubble=1, else the computed value. Selects are valid one cycle after ID, aligned with the instruction in EX.
- After a one-cycle load-use stall the load has moved to mem_rec, so the retried instruction gets select 01.
- Register file is write-before-read; the WB stage needs no forwarding.
- stall_cnt increments by 1 on each edge where stall=1, wraps at 2^CNT_W-1 -> 0.
- ex_flush together with load_use: flush wins; stall=0, bubble=1, counter unchanged.
- id_uses_*=0 suppresses matching for that operand (immediates, shifts).

Decomposition:
- Shared package fwd_pkg:
  - constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_EX=2'b10 (match the 3:1 mux ordering inA/inB/inC);
  - pipe_rec_t struct {valid, regwrite, memread, dest};
  - REG_ZERO constant.
- One natural sub-module, fwd_match: given src, uses and two records, returns the 2-bit select and a load-hit flag. Instantiated twice (A, B).

Test Plan:
- Reset: hold Rst 2 cycles mid-traffic -> fwd_a_sel=fwd_b_sel=00, stall=0, stall_cnt=0 next cycle.
- EX forward: add $8 in ID, next cycle sub reading rs=$8 in ID -> fwd_a_sel=10 the following cycle, stall=0.
- MEM forward: add $9, then independent op, then or rt=$9 -> fwd_b_sel=01. Repeat with dest=$0 -> 00.
- Load-use: lw $10, then add rs=$10 -> stall=1 and idex_bubble=1 for exactly 1 cycle, stall_cnt=1. Retried add gets fwd_a_sel=01.
- Priority: add $11, add $11, then sub rs=$11 -> fwd_a_sel=10 (newest producer).
- Flush vs stall: lw $12 then add rs=$12 with ex_flush=1 the same cycle -> stall=0, idex_bubble=1, stall_cnt unchanged, next fwd_a_sel=00.
